// File: rtl/quick_q_pkg.sv
// Shared types and defaults for the QuickQ priority-queue core.
package quick_q_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 32;

    // Operation reported on mux1_sel for the previous cycle.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_ENQ     = 2'b01,
        OP_DEQ     = 2'b10,
        OP_RPL_ERR = 2'b11
    } op_e;

    // Per-cycle command broadcast to every slot cell.
    typedef enum logic [1:0] {
        CELL_HOLD  = 2'b00,  // keep contents
        CELL_INS   = 2'b01,  // insert key, entries above the insertion point move up
        CELL_SHIFT = 2'b10,  // pop head, every entry moves down
        CELL_RPL   = 2'b11   // pop head and insert key into the remaining entries
    } cell_op_e;

endpackage

// File: rtl/quick_q_cell.sv
// One slot of the sorted register array; picks hold / key / left / right.
module quick_q_cell
    import quick_q_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter bit FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  cell_op_e         op,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] left,      // slot of the lower-index neighbour
    input  logic [WIDTH-1:0] right,     // slot of the higher-index neighbour
    input  logic             valid,     // this slot holds a live entry
    input  logic             lt_left,   // key belongs at or before the left neighbour
    input  logic             lt_right,  // key belongs at or before the right neighbour
    output logic [WIDTH-1:0] slot,
    output logic             lt_self    // key belongs at or before this slot
);

    logic [WIDTH-1:0] slot_nxt;

    // Empty slots always accept the key, so the flag chain stays monotonic.
    assign lt_self = ~valid | (key < slot);

    // Select the next slot value from the broadcast command and neighbour flags.
    always_comb begin
        // NOTE: default first so every path assigns slot_nxt and no latch is inferred.
        slot_nxt = slot;
        case (op)
            CELL_INS:   slot_nxt = lt_left ? left : (lt_self ? key : slot);
            CELL_SHIFT: slot_nxt = right;
            // The head is being popped, so its own flag never keeps it in place.
            CELL_RPL:   slot_nxt = (lt_self && !FIRST) ? slot : (lt_right ? key : right);
            default:    slot_nxt = slot;
        endcase
    end

    // Slot register; cleared on reset so unused slots read as 0.
    always_ff @(posedge clk) begin
        // NOTE: the key storage is reset explicitly because empty slots must read 0.
        if (rst) slot <= '0;
        // NOTE: non-blocking assignment for all clocked state.
        else     slot <= slot_nxt;
    end

endmodule

// File: rtl/quick_q_core.sv
// Register-based min-priority queue core with tail eviction for cascading.
module quick_q_core
    import quick_q_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] to_register,
    output logic             regenb,
    output logic [WIDTH-1:0] data_lt_o,
    output logic             next_node,
    output logic [1:0]       mux1_sel
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] slot     [DEPTH];
    logic [WIDTH-1:0] slot_ext [DEPTH+2];  // slots padded with a zero at each end
    logic [DEPTH-1:0] lt;
    logic [DEPTH+1:0] lt_ext;              // flags padded: never before head, always after tail
    logic             empty;
    logic             full;
    cell_op_e         cell_op;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign slot_ext[0]       = '0;
    assign slot_ext[DEPTH+1] = '0;
    assign lt_ext            = {1'b1, lt, 1'b0};

    // Translate the request pair into the command every cell applies.
    always_comb begin
        cell_op = CELL_HOLD;
        case ({enq, deq})
            2'b10:   cell_op = CELL_INS;
            2'b01:   cell_op = empty ? CELL_HOLD : CELL_SHIFT;
            2'b11:   cell_op = empty ? CELL_HOLD : CELL_RPL;
            default: cell_op = CELL_HOLD;
        endcase
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        assign slot_ext[g+1] = slot[g];

        quick_q_cell #(
            .WIDTH (WIDTH),
            .FIRST (g == 0)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .op       (cell_op),
            .key      (reg_out),
            .left     (slot_ext[g]),
            .right    (slot_ext[g+2]),
            .valid    (count > CW'(g)),
            .lt_left  (lt_ext[g]),
            .lt_right (lt_ext[g+2]),
            .slot     (slot[g]),
            .lt_self  (lt[g])
        );
    end

    // Occupancy count and registered outputs for the operation just performed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            to_register <= '0;
            regenb      <= 1'b0;
            data_lt_o   <= '0;
            next_node   <= 1'b0;
            mux1_sel    <= OP_IDLE;
        end else begin
            regenb    <= 1'b0;
            next_node <= 1'b0;
            mux1_sel  <= OP_IDLE;
            case ({enq, deq})
                2'b10: begin
                    mux1_sel <= OP_ENQ;
                    if (full) begin
                        // The larger of the incoming key and the current tail leaves.
                        next_node <= 1'b1;
                        data_lt_o <= lt[DEPTH-1] ? slot[DEPTH-1] : reg_out;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty) begin
                        mux1_sel <= OP_RPL_ERR;
                    end else begin
                        mux1_sel    <= OP_DEQ;
                        regenb      <= 1'b1;
                        to_register <= slot[0];
                        count       <= count - CW'(1);
                    end
                end
                2'b11: begin
                    mux1_sel    <= OP_RPL_ERR;
                    regenb      <= 1'b1;
                    to_register <= empty ? reg_out : slot[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quick_q_core.sv
// Self-checking bench for quick_q_core: directed table, corner sequences, random vs model.
module tb_quick_q_core;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enq = 1'b0;
    logic             deq = 1'b0;
    logic [WIDTH-1:0] reg_out = '0;
    logic [WIDTH-1:0] to_register;
    logic             regenb;
    logic [WIDTH-1:0] data_lt_o;
    logic             next_node;
    logic [1:0]       mux1_sel;

    quick_q_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enq         (enq),
        .deq         (deq),
        .reg_out     (reg_out),
        .to_register (to_register),
        .regenb      (regenb),
        .data_lt_o   (data_lt_o),
        .next_node   (next_node),
        .mux1_sel    (mux1_sel)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: a sorted list plus the last value on each output.
    int unsigned mq[$];
    logic [31:0] m_to;
    logic [31:0] m_dlt;
    bit          m_regenb;
    bit          m_next;
    logic [1:0]  m_mux;

    typedef struct {
        bit          enq;
        bit          deq;
        logic [31:0] key;
        bit          regenb;
        logic [31:0] to_reg;
        bit          next;
        logic [31:0] dlt;
        logic [1:0]  mux;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit e, bit d, int unsigned k, bit rg, int unsigned tr,
                                bit nx, int unsigned dl, logic [1:0] mx);
        vec_t v;
        v.enq = e; v.deq = d; v.key = k; v.regenb = rg; v.to_reg = tr;
        v.next = nx; v.dlt = dl; v.mux = mx;
        vecs.push_back(v);
    endfunction

    function automatic void model_insert(int unsigned k);
        int p = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i] > k) begin
                p = i;
                break;
            end
        end
        mq.insert(p, k);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_to = 0; m_dlt = 0; m_regenb = 0; m_next = 0; m_mux = 2'b00;
    endfunction

    function automatic void model_step(bit e, bit d, int unsigned k);
        m_regenb = 0;
        m_next   = 0;
        m_mux    = 2'b00;
        if (e && !d) begin
            m_mux = 2'b01;
            model_insert(k);
            if (mq.size() > DEPTH) begin
                m_dlt  = mq.pop_back();
                m_next = 1;
            end
        end else if (!e && d) begin
            if (mq.size() > 0) begin
                m_to     = mq.pop_front();
                m_regenb = 1;
                m_mux    = 2'b10;
            end else begin
                m_mux = 2'b11;
            end
        end else if (e && d) begin
            m_mux    = 2'b11;
            m_regenb = 1;
            if (mq.size() > 0) begin
                m_to = mq.pop_front();
                model_insert(k);
            end else begin
                m_to = k;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string name, input bit rg, input logic [31:0] tr,
                             input bit nx, input logic [31:0] dl, input logic [1:0] mx);
        check({name, " regenb"},      32'(regenb),    32'(rg));
        check({name, " to_register"}, to_register,    tr);
        check({name, " next_node"},   32'(next_node), 32'(nx));
        check({name, " data_lt_o"},   data_lt_o,      dl);
        check({name, " mux1_sel"},    32'(mux1_sel),  32'(mx));
    endtask

    // Apply one request for exactly one edge, then sample 1 ns later.
    task automatic step(input bit e, input bit d, input logic [31:0] k);
        @(negedge clk);
        enq = e; deq = d; reg_out = k;
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0;
        model_step(e, d, k);
    endtask

    task automatic do_reset(input bit e, input logic [31:0] k);
        @(negedge clk);
        rst = 1'b1; enq = e; reg_out = k;
        @(posedge clk);
        #1;
        rst = 1'b0; enq = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Directed table starting from reset.
        add(0,1, 0, 0,0,0,0, 2'b11);
        add(0,0, 0, 0,0,0,0, 2'b00);
        add(1,0, 5, 0,0,0,0, 2'b01);
        add(0,1, 0, 1,5,0,0, 2'b10);
        add(0,1, 0, 0,5,0,0, 2'b11);
        add(1,0, 9, 0,5,0,0, 2'b01);
        add(1,0, 3, 0,5,0,0, 2'b01);
        add(1,0, 7, 0,5,0,0, 2'b01);
        add(1,0, 3, 0,5,0,0, 2'b01);
        add(0,1, 0, 1,3,0,0, 2'b10);
        add(0,1, 0, 1,3,0,0, 2'b10);
        add(0,1, 0, 1,7,0,0, 2'b10);
        add(0,1, 0, 1,9,0,0, 2'b10);
        for (int k = 1; k <= 8; k++) add(1,0, k, 0,9,0,0, 2'b01);
        add(1,0, 4,  0,9,1,8,  2'b01);
        add(1,0, 20, 0,9,1,20, 2'b01);
        add(0,0, 0,  0,9,0,20, 2'b00);
        add(0,1, 0, 1,1,0,20, 2'b10);
        add(0,1, 0, 1,2,0,20, 2'b10);
        add(0,1, 0, 1,3,0,20, 2'b10);
        add(0,1, 0, 1,4,0,20, 2'b10);
        add(0,1, 0, 1,4,0,20, 2'b10);
        add(0,1, 0, 1,5,0,20, 2'b10);
        add(0,1, 0, 1,6,0,20, 2'b10);
        add(0,1, 0, 1,7,0,20, 2'b10);
        add(0,1, 0, 0,7,0,20, 2'b11);
        add(0,0, 0, 0,7,0,20, 2'b00);

        do_reset(1'b0, '0);
        check_all("reset", 0, 0, 0, 0, 2'b00);

        foreach (vecs[i]) begin
            step(vecs[i].enq, vecs[i].deq, vecs[i].key);
            check_all($sformatf("vec%0d", i), vecs[i].regenb, vecs[i].to_reg,
                      vecs[i].next, vecs[i].dlt, vecs[i].mux);
        end

        // Replace on a two-entry queue, then drain.
        step(1, 0, 2);
        step(1, 0, 6);
        step(1, 1, 4);
        check_all("rpl pop", 1, 2, 0, 20, 2'b11);
        step(0, 1, 0);
        check_all("rpl drain0", 1, 4, 0, 20, 2'b10);
        step(0, 1, 0);
        check_all("rpl drain1", 1, 6, 0, 20, 2'b10);
        step(0, 1, 0);
        check_all("rpl empty", 0, 6, 0, 20, 2'b11);

        // Pass-through on an empty queue leaves it empty.
        step(1, 1, 11);
        check_all("pass", 1, 11, 0, 20, 2'b11);
        step(0, 1, 0);
        check_all("pass after", 0, 11, 0, 20, 2'b11);

        // Reset wins over a coincident enqueue and clears stored keys.
        step(1, 0, 7);
        do_reset(1'b1, 3);
        check_all("rst prio", 0, 0, 0, 0, 2'b00);
        step(0, 1, 0);
        check_all("rst prio deq", 0, 0, 0, 0, 2'b11);

        // Random traffic against the model, with ties and near-max keys.
        for (int n = 0; n < 800; n++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [31:0] k = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom_range(0, 15));
            bit e = (r <= 4) || (r == 8);
            bit d = ((r >= 5) && (r <= 7)) || (r == 8);
            step(e, d, k);
            check_all($sformatf("rnd%0d", n), m_regenb, m_to, m_next, m_dlt, m_mux);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
